choose_display_sel: RTL and testbench

//   Selects which game value the slot-machine 7-segment path shows.

---
 rtl/choose_display_sel_pkg.sv | 9 +
 rtl/choose_display_sel_if.sv | 28 ++
 rtl/choose_display_sel_sync.sv | 27 ++
 rtl/choose_display_sel.sv | 62 ++++++
 tb/tb_choose_display_sel.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/choose_display_sel_pkg.sv
// Shared game-wide types for the slot-machine datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   MONEY_W : bit width of money / balance values
//   money_t : raw money value; balance is two's complement, invested is unsigned
package game_pkg;
  localparam int MONEY_W = 11;
  typedef logic [MONEY_W-1:0] money_t;
endpackage

// File: rtl/choose_display_sel_if.sv
// Bundle between game-state logic and the 7-segment display select block.
// Latency: n/a (wires only).
// Backpressure: none; values are sampled every gameClk edge.
// master : drives button and game values, observes display outputs
// slave  : the display select block
interface choose_display_sel_if
  import game_pkg::*;
#(
  parameter int WIDTH = MONEY_W
);
  logic             status_btn;              // async push button, 1 = show balance
  logic [WIDTH-1:0] current_money_invested;  // unsigned bet this round
  logic [WIDTH-1:0] current_balance;         // signed player balance
  logic [WIDTH-1:0] number_to_display;       // selected raw value
  logic             display_sel;             // 1 = balance shown
  logic             display_neg;             // 1 = shown value negative
  logic [WIDTH-1:0] display_mag;             // magnitude of shown value

  modport master (
    output status_btn, current_money_invested, current_balance,
    input  number_to_display, display_sel, display_neg, display_mag
  );

  modport slave (
    input  status_btn, current_money_invested, current_balance,
    output number_to_display, display_sel, display_neg, display_mag
  );
endinterface

// File: rtl/choose_display_sel_sync.sv
// Flop-chain synchroniser for the asynchronous status button.
// Latency: SYNC_STAGES gameClk cycles from i_btn to o_btn_s.
// Backpressure: none.
//   i_clk, i_rst (sync, active-high) ; i_btn async in ; o_btn_s synchronised out
module btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_btn_s
);
  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_btn_s = r_chain[SYNC_STAGES-1];
endmodule

// File: rtl/choose_display_sel.sv
// Picks balance (button held) or money invested for the 7-segment path, with sign/magnitude.
// Latency: 1 cycle from data inputs, SYNC_STAGES+1 cycles from status_btn.
// Backpressure: none; outputs update on every non-reset gameClk edge.
//   gameClk : game clock      rst : sync active-high reset
//   bus     : slave side of choose_display_sel_if (button, values in; display values out)
module choose_display_sel
  import game_pkg::*;
#(
  parameter int WIDTH       = MONEY_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 gameClk,
  input  logic                 rst,
  choose_display_sel_if.slave  bus
);
  logic             w_btn_s;
  logic [WIDTH-1:0] w_sel_val;
  logic             w_neg;
  logic [WIDTH-1:0] w_mag;

  logic [WIDTH-1:0] r_number;
  logic             r_sel;
  logic             r_neg;
  logic [WIDTH-1:0] r_mag;

  btn_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .i_clk   (gameClk),
    .i_rst   (rst),
    .i_btn   (bus.status_btn),
    .o_btn_s (w_btn_s)
  );

  always_comb begin
    w_sel_val = w_btn_s ? bus.current_balance : bus.current_money_invested;
    // Invested is unsigned, so only a selected balance can be negative.
    w_neg     = w_btn_s & bus.current_balance[WIDTH-1];
    // The most negative balance negates to itself, whose unsigned reading
    // is exactly the wanted magnitude 2^(WIDTH-1).
    w_mag     = w_neg ? ('0 - w_sel_val) : w_sel_val;
  end

  always_ff @(posedge gameClk) begin
    if (rst) begin
      r_number <= '0;
      r_sel    <= 1'b0;
      r_neg    <= 1'b0;
      r_mag    <= '0;
    end else begin
      r_number <= w_sel_val;
      r_sel    <= w_btn_s;
      r_neg    <= w_neg;
      r_mag    <= w_mag;
    end
  end

  assign bus.number_to_display = r_number;
  assign bus.display_sel       = r_sel;
  assign bus.display_neg       = r_neg;
  assign bus.display_mag       = r_mag;
endmodule

// File: tb/tb_choose_display_sel.sv
// Self-checking bench for choose_display_sel: scoreboard plus directed spot checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_choose_display_sel;
  import game_pkg::*;

  localparam int N = 2;  // button synchroniser depth

  logic gameClk = 1'b0;
  logic rst;
  always #5 gameClk = ~gameClk;

  choose_display_sel_if #(.WIDTH(MONEY_W)) bus();

  choose_display_sel #(
    .WIDTH       (MONEY_W),
    .SYNC_STAGES (N)
  ) dut (
    .gameClk (gameClk),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    money_t num;
    logic   sel;
    logic   neg;
    money_t mag;
    string  tag;
  } exp_t;

  int     vectors     = 0;
  int     miscompares = 0;
  exp_t   sb[$];
  bit     btn_log[$];
  int     edge_k      = 0;
  int     last_rst    = -1000;
  bit     run         = 1'b1;
  string  phase       = "reset";

  // Reference: the button seen by the mux is the one applied N edges ago,
  // unless a reset happened at or after that edge.
  always @(posedge gameClk) begin : sampler
    exp_t e;
    int   src;
    bit   bs;
    int   sv;
    if (run) begin
      btn_log.push_back(bus.status_btn === 1'b1);
      e.tag = phase;
      if (rst) begin
        last_rst = edge_k;
        e.num = '0; e.sel = 1'b0; e.neg = 1'b0; e.mag = '0;
      end else begin
        src = edge_k - N;
        bs  = (src >= 0 && src > last_rst) ? btn_log[src] : 1'b0;
        if (bs) begin
          sv = int'(bus.current_balance);
          if (sv >= (1 << (MONEY_W - 1))) sv = sv - (1 << MONEY_W);
          e.num = bus.current_balance;
          e.sel = 1'b1;
          e.neg = (sv < 0);
          e.mag = money_t'((sv < 0) ? -sv : sv);
        end else begin
          e.num = bus.current_money_invested;
          e.sel = 1'b0;
          e.neg = 1'b0;
          e.mag = bus.current_money_invested;
        end
      end
      sb.push_back(e);
      edge_k++;
    end
  end

  always @(posedge gameClk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (bus.number_to_display !== e.num || bus.display_sel !== e.sel ||
          bus.display_neg !== e.neg || bus.display_mag !== e.mag) begin
        miscompares++;
        $display("FAIL sb[%s] t=%0t: got num=%h sel=%b neg=%b mag=%h, want num=%h sel=%b neg=%b mag=%h",
                 e.tag, $time, bus.number_to_display, bus.display_sel, bus.display_neg,
                 bus.display_mag, e.num, e.sel, e.neg, e.mag);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge gameClk);
  endtask

  task automatic chk(input string name, input money_t num, input logic sel,
                     input logic neg, input money_t mag);
    vectors++;
    if (bus.number_to_display !== num || bus.display_sel !== sel ||
        bus.display_neg !== neg || bus.display_mag !== mag) begin
      miscompares++;
      $display("FAIL %s: got num=%h sel=%b neg=%b mag=%h, want num=%h sel=%b neg=%b mag=%h",
               name, bus.number_to_display, bus.display_sel, bus.display_neg,
               bus.display_mag, num, sel, neg, mag);
    end
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    bus.status_btn = 1'b1;
    bus.current_money_invested = 11'd20;
    bus.current_balance = 11'd5;
    cyc(2);
    chk("reset", 11'd0, 1'b0, 1'b0, 11'd0);

    phase = "invested";
    rst = 1'b0;
    bus.status_btn = 1'b0;
    bus.current_balance = 11'h7E7;
    cyc(1);
    chk("invested_1cyc", 11'd20, 1'b0, 1'b0, 11'd20);
    cyc(2);

    phase = "btn_rise";
    bus.status_btn = 1'b1;
    cyc(2);
    chk("btn_rise_edge2", 11'd20, 1'b0, 1'b0, 11'd20);
    cyc(1);
    chk("btn_rise_edge3", 11'h7E7, 1'b1, 1'b1, 11'd25);

    phase = "boundary";
    bus.current_balance = 11'h400;
    cyc(1);
    chk("most_negative", 11'h400, 1'b1, 1'b1, 11'd1024);
    bus.current_balance = 11'h3FF;
    cyc(1);
    chk("most_positive", 11'h3FF, 1'b1, 1'b0, 11'd1023);

    phase = "data_latency";
    bus.current_balance = 11'd7;
    cyc(1);
    bus.current_balance = 11'd100;
    cyc(1);
    chk("balance_1cyc", 11'd100, 1'b1, 1'b0, 11'd100);
    bus.status_btn = 1'b0;
    cyc(2);
    chk("btn_fall_edge2", 11'd100, 1'b1, 1'b0, 11'd100);
    cyc(1);
    chk("btn_fall_edge3", 11'd20, 1'b0, 1'b0, 11'd20);

    phase = "mid_reset";
    bus.status_btn = 1'b1;
    bus.current_balance = 11'h7E7;
    cyc(3);
    chk("pre_reset", 11'h7E7, 1'b1, 1'b1, 11'd25);
    rst = 1'b1;
    cyc(1);
    chk("mid_reset", 11'd0, 1'b0, 1'b0, 11'd0);
    rst = 1'b0;
    cyc(2);
    chk("post_reset_edge2", 11'd20, 1'b0, 1'b0, 11'd20);
    cyc(1);
    chk("post_reset_edge3", 11'h7E7, 1'b1, 1'b1, 11'd25);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) bus.status_btn = ~bus.status_btn;
      bus.current_money_invested = money_t'($urandom);
      bus.current_balance = ($urandom_range(0, 9) == 0) ? 11'h400 : money_t'($urandom);
      cyc(1);
    end
    rst = 1'b0;
    cyc(4);

    run = 1'b0;
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      cyc(1);
      waited++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
